// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replicated data, load extraction/extension, access checks.
// Latency: purely combinational.
// Backpressure: none; pure function of its inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rd2,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = mem_rdata[{addr, 3'b000} +: 8];
    assign half_v = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        be         = '0;
        wdata      = '0;
        rdata      = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr;
                wdata = {4{rd2[7:0]}};
                rdata = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            end
            F3_H, F3_HU: begin
                // addr[0] only matters for the alignment check
                be         = addr[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{rd2[15:0]}};
                rdata      = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
                misaligned = addr[0];
            end
            F3_W: begin
                be         = 4'b1111;
                wdata      = rd2;
                rdata      = mem_rdata;
                misaligned = (addr != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: req/gnt/rvalid handshake to data memory with timeout and error reporting.
// Latency: store 2 cycles, load 3 cycles minimum, error 1 cycle after start.
// Backpressure: stall held from start until the done cycle; waits on mem_gnt/mem_rvalid.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] rd2,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        op_we_q, op_we_d;
    logic [2:0]  op_f3_q, op_f3_d;
    logic [1:0]  op_off_q, op_off_d;
    logic [31:0] op_rd2_q, op_rd2_d;

    logic [31:0] read_data_q, read_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        idle;
    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [31:0] sel_rd2;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misaligned, al_illegal;
    logic        timeout;

    // In IDLE the live operands are checked; afterwards the latched copies drive extraction.
    assign idle    = (state_q == IDLE);
    assign sel_f3  = idle ? funct3 : op_f3_q;
    assign sel_off = idle ? alu_result[1:0] : op_off_q;
    assign sel_rd2 = idle ? rd2 : op_rd2_q;
    assign timeout = (cnt_q == CW'(MAX_WAIT - 1));

    lsu_align u_align (
        .funct3     (sel_f3),
        .addr       (sel_off),
        .rd2        (sel_rd2),
        .mem_rdata  (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .rdata      (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_we_d     = op_we_q;
        op_f3_d     = op_f3_q;
        op_off_d    = op_off_q;
        op_rd2_d    = op_rd2_q;
        read_data_d = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_we_d  = mem_write;
                    op_f3_d  = funct3;
                    op_off_d = alu_result[1:0];
                    op_rd2_d = rd2;
                    if (al_misaligned || al_illegal) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_addr_d  = {alu_result[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_gnt) begin
                    cnt_d = '0;
                    if (op_we_q) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_be_d    = mem_be_q;
                    mem_wdata_d = mem_wdata_q;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rvalid) begin
                    state_d     = RESP;
                    done_d      = 1'b1;
                    read_data_d = al_rdata;
                end else if (timeout) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_we_q     <= 1'b0;
            op_f3_q     <= '0;
            op_off_q    <= '0;
            op_rd2_q    <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_we_q     <= op_we_d;
            op_f3_q     <= op_f3_d;
            op_off_q    <= op_off_d;
            op_rd2_q    <= op_rd2_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign read_data = read_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign stall     = !idle || start;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store stage directly downstream of the ALU datapath. It takes the ALU result as the byte address and register read port 2 as store data. It runs a request/grant/response handshake with data memory and returns a sign- or zero-extended load value to the writeback mux. It holds `stall` high for the whole access so the PC and register file freeze until the access completes.

## Interface
- `MAX_WAIT`, default 15: cycles allowed in REQ or WAIT before the access aborts with `err`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle pulse; begin an access with the operands currently presented.
- `mem_write` input 1: 1 = store, 0 = load.
- `funct3` input 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other codes are illegal.
- `alu_result` input 32: byte address.
- `rd2` input 32: store data.
- `read_data` output 32: extended load result; valid while `done` is high.
- `stall` output 1: access in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: qualifies `done`; misaligned address, illegal funct3, or timeout.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write enable.
- `mem_addr` output 32: word address, {alu_result[31:2], 2'b00}.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-shifted store data.
- `mem_gnt` input 1: request accepted.
- `mem_rvalid` input 1: load data valid.
- `mem_rdata` input 32: load word.

## Operation
- **Latch on start:** in IDLE, `start` registers `mem_write`, `funct3`, `alu_result` and `rd2`. Inputs are don't-care afterwards.
- **State IDLE:**
  - `start` with a legal, aligned access goes to REQ.
  - `start` with a misaligned or illegal access goes to RESP with `err` set. No memory traffic.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - `start` outside IDLE is ignored.
- **State REQ:** `mem_req`=1; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable.
  - `mem_gnt`=1 with a store goes to RESP.
  - `mem_gnt`=1 with a load goes to WAIT.
- **State WAIT:** `mem_req`=0. `mem_rvalid`=1 captures `mem_rdata` and goes to RESP.
  - `mem_rvalid` arriving in the same cycle as `mem_gnt` is not accepted; rvalid is only sampled in WAIT.
- **State RESP:** `done`=1 for one cycle, then IDLE.
- **Timeout:** a wait counter clears on entering REQ or WAIT and increments each cycle spent there. Reaching `MAX_WAIT` goes to RESP with `err`=1 and `read_data`=0.
- **Byte enables:** B gives 0001<<addr[1:0]. H gives 0011<<addr[1:0] (addr[1] only). W gives 1111.
- **Store data:** `mem_wdata` = `rd2` replicated into every lane (B: {4{rd2[7:0]}}, H: {2{rd2[15:0]}}, W: `rd2`).
- **Load extraction:**
  - The byte or half is selected by addr[1:0].
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
  - Stores and errored accesses return `read_data`=0.

## Timing
- **Reset values:** state IDLE, counter 0, and all outputs 0 (including `read_data`, `mem_addr` and `mem_be`).
- **Outputs are registered** except `stall`, which is combinational: `stall` = (state≠IDLE) | `start`. It therefore rises in the start cycle.
- **Minimum latency, start at edge 0:**
  - Store: REQ in cycle 1; with `mem_gnt` in cycle 1, `done` in cycle 2.
  - Load: REQ in cycle 1, WAIT in cycle 2; with `mem_rvalid` in cycle 2, `done` in cycle 3.
  - Error: `done`+`err` in cycle 1.
- **`stall` falls** in the cycle after `done`. `done` and `stall` are both high in the RESP cycle.
- **Reset mid-access:** `rst_n` low returns to IDLE immediately and clears `mem_req` combinatorially with respect to the flops. No `done` is issued for the aborted access.

## Structure
- **Package `lsu_pkg`:**
  - funct3 encodings as localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - typedef enum state_t {IDLE, REQ, WAIT, RESP}.
- **Sub-module `lsu_align`:** purely combinational.
  - Inputs: funct3, addr[1:0], rd2, mem_rdata.
  - Outputs: `be`, `wdata`, extended `rdata`, `misaligned`, `illegal`.
- **Top level** contains the FSM, the operand registers and the timeout counter.

## Test plan
- SW at addr 0x100, `rd2`=0xDEADBEEF, `mem_gnt` in cycle 1 → `mem_be`=1111, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF; `done` in cycle 2, `err`=0.
- LB at 0x103, `mem_rdata`=0x80FF_0000, rvalid two cycles after gnt → `read_data`=0xFFFFFF80. LBU under the same stimulus → 0x00000080.
- SH at 0x102, `rd2`=0x1234ABCD → `mem_be`=1100, `mem_wdata`=0xABCDABCD. LHU at 0x102 with rdata 0xABCD0000 → 0x0000ABCD.
- LW at 0x101 → no `mem_req`, `done`+`err` in cycle 1, `read_data`=0. funct3=011 gives the same response.
- `mem_gnt` held low with `MAX_WAIT`=15 → `done`+`err` 15 cycles after REQ entry; `stall` high throughout.
- `rst_n` pulsed low in WAIT → all outputs 0 immediately. A following start/gnt/rvalid runs a normal load.
